alu_issue_queue: RTL and testbench

//  Operand/instruction issue queue directly upstream of the ALU datapath.

---
 rtl/alu_issue_queue.sv | 89 ++++++++
 tb/tb_alu_issue_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Show-ahead issue queue that buffers {A, B, instruction} triples in front of the ALU.
// Optional synchronous flush port is enabled by defining ALU_ISSUE_QUEUE_FLUSH_EN.
module alu_issue_queue #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_a,
    input  logic [N-1:0]               in_b,
    input  logic [M-1:0]               in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               A,
    output logic [N-1:0]               B,
    output logic [M-1:0]               instruction,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 2 * N + M;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          clear;

    // Handshake: a transfer happens on an edge where valid and ready are both 1.
    // in_ready is !full from registered count only, so a pop in the same cycle
    // never opens a slot for a push; out_valid is !empty and the head stays put
    // until it is taken.
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    // Storage is never reset; count and pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= {in_a, in_b, in_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is shown combinationally and zeroed when nothing is queued.
    assign head = mem[rd_ptr];
    assign {A, B, instruction} = empty ? '0 : head;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_alu_issue_queue;

    localparam int N     = 4;
    localparam int M     = 4;
    localparam int DEPTH = 4;
    localparam int W     = 2 * N + M;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic [M-1:0]  in_instr = '0;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  a_out;
    logic [N-1:0]  b_out;
    logic [M-1:0]  instr_out;
    logic [CW-1:0] count;
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
    logic          flush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    alu_issue_queue #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
        .flush       (flush),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .A           (a_out),
        .B           (b_out),
        .instruction (instr_out),
        .count       (count)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: the model is simply the ordered list of live entries.
    task automatic compare_outputs(input string tag);
        int sz;
        logic [W-1:0] head_exp;
        sz = exp_q.size();
        head_exp = (sz > 0) ? exp_q[0] : '0;
        check({tag, ".count"},     32'(count),     32'(sz));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(sz > 0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(sz < DEPTH));
        check({tag, ".head"},      32'({a_out, b_out, instr_out}), 32'(head_exp));
    endtask

    // Driver: apply one cycle of inputs, check the pre-edge state, advance the model.
    task automatic step(input string tag, input logic iv, input logic orr,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [M-1:0] ins, input logic fl);
        int sz;
        in_valid  = iv;
        out_ready = orr;
        in_a      = a;
        in_b      = b;
        in_instr  = ins;
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
        flush     = fl;
`endif
        #1;
        compare_outputs(tag);
        sz = exp_q.size();
        if (fl) begin
            exp_q.delete();
        end else begin
            if (orr && sz > 0) void'(exp_q.pop_front());
            if (iv && sz < DEPTH) exp_q.push_back({a, b, ins});
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
        flush     = 1'b0;
`endif
    endtask

    task automatic apply_reset(input int edges);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_a     = 4'hE;
        repeat (edges) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        exp_q.delete();
        compare_outputs("reset");
    endtask

    initial begin
        // Initial reset held for two edges
        apply_reset(2);

        // Two pushes, hold head, then drain
        step("push1", 1, 0, 4'h3, 4'h5, 4'b0001, 0);
        step("push2", 1, 0, 4'h9, 4'h2, 4'b1010, 0);
        step("hold1", 0, 0, 4'h0, 4'h0, 4'h0, 0);
        step("hold2", 0, 0, 4'h0, 4'h0, 4'h0, 0);
        step("pop1",  0, 1, 4'h0, 4'h0, 4'h0, 0);
        step("pop2",  0, 1, 4'h0, 4'h0, 4'h0, 0);
        step("empty_pop", 0, 1, 4'h0, 4'h0, 4'h0, 0);

        // Fill, attempt overflow push (also with a pop the same cycle), then drain
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1, 0, 4'(i + 1), 4'(i + 8), 4'(i), 0);
        end
        step("overflow", 1, 0, 4'hF, 4'hF, 4'hF, 0);
        step("full_pushpop", 1, 1, 4'hF, 4'hE, 4'hD, 0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            step("drain", 0, 1, 4'h0, 4'h0, 4'h0, 0);
        end

        // Streaming push+pop at count=2 across pointer wrap
        step("pre1", 1, 0, 4'h1, 4'h2, 4'h3, 0);
        step("pre2", 1, 0, 4'h4, 4'h5, 4'h6, 0);
        for (int i = 0; i < 6; i++) begin
            step("stream", 1, 1, 4'(i + 7), 4'(15 - i), 4'(i * 3), 0);
        end
        step("post_stream", 0, 0, 4'h0, 4'h0, 4'h0, 0);

        // Reset with three entries queued
        step("rfill", 1, 0, 4'hA, 4'h1, 4'h2, 0);
        step("rfill", 1, 0, 4'hB, 4'h3, 4'h4, 0);
        step("rfill", 1, 0, 4'hC, 4'h5, 4'h6, 0);
        step("rfull3", 0, 0, 4'h0, 4'h0, 4'h0, 0);
        apply_reset(1);
        step("after_reset", 0, 1, 4'h0, 4'h0, 4'h0, 0);
        step("after_reset_push", 1, 0, 4'h7, 4'h7, 4'h7, 0);
        step("after_reset_pop", 0, 1, 4'h0, 4'h0, 4'h0, 0);
        step("after_reset_idle", 0, 0, 4'h0, 4'h0, 4'h0, 0);

`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
        // Flush with three entries and a concurrent push
        step("ffill", 1, 0, 4'h1, 4'h1, 4'h1, 0);
        step("ffill", 1, 0, 4'h2, 4'h2, 4'h2, 0);
        step("ffill", 1, 0, 4'h3, 4'h3, 4'h3, 0);
        step("flush", 1, 1, 4'h9, 4'h9, 4'h9, 1);
        step("after_flush", 0, 1, 4'h0, 4'h0, 4'h0, 0);
`endif

        // Random traffic with shifting push/pop bias
        for (int i = 0; i < 400; i++) begin
            int pv;
            int pr;
            logic fl;
            pv = (i / 100) % 2 == 0 ? 70 : 30;
            pr = (i / 100) % 2 == 0 ? 30 : 70;
            fl = 1'b0;
`ifdef ALU_ISSUE_QUEUE_FLUSH_EN
            fl = ($urandom_range(0, 49) == 0);
`endif
            step("rand", $urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr,
                 N'($urandom), N'($urandom), M'($urandom), fl);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step("final_drain", 0, 1, 4'h0, 4'h0, 4'h0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
